// File: rtl/l2q_pkg.sv
// Shared constants for the L2 request queue: trace command codes and default line-address width.
package l2q_pkg;

  localparam logic [3:0] CMD_RESET  = 4'd8;
  localparam logic [3:0] CMD_PRINT  = 4'd9;
  localparam int         ADDR_W_DEF = 26;

endpackage

// File: rtl/l2q_fifo.sv
// Circular line-address store for the L2 request queue: storage, head/tail pointers, occupancy and flags.
import l2q_pkg::*;

module l2q_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          push_data,
  output logic [ADDR_W-1:0]          head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0]     head_ptr;
  logic [PW-1:0]     tail_ptr;

  // Pointers are exactly PW bits wide, so DEPTH being a power of two gives free wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PW'(1);
      if (pop)  head_ptr <= head_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail_ptr] <= push_data;
  end

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign head_data = empty ? '0 : mem[head_ptr];

endmodule

// File: rtl/l2_req_queue.sv
// L2 request queue: buffers data-cache line addresses toward the next-level cache with statistics.
// Optional build macro L2Q_COALESCE_EN merges a request that repeats the youngest queued address.
import l2q_pkg::*;

module l2_req_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             n,
  input  logic                   req_valid,
  input  logic [ADDR_W-1:0]      req_addr,
  output logic                   mem_valid,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ready,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [31:0]            enq_cnt,
  output logic [31:0]            drop_cnt,
  output logic [31:0]            merge_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic flush;
  logic pop;
  logic push;
  logic drop;
  logic merge;

  assign flush     = (n == CMD_RESET);
  assign mem_valid = !empty;
  assign pop       = mem_valid && mem_ready && !flush;

`ifdef L2Q_COALESCE_EN
  // Tail only ever advances on push, so the last accepted address is the youngest entry.
  logic [ADDR_W-1:0] last_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_addr <= '0;
    else if (push) last_addr <= req_addr;
  end

  assign merge = req_valid && !flush && !empty && (req_addr == last_addr) &&
                 !((count == CW'(1)) && pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     merge_cnt <= '0;
    else if (flush) merge_cnt <= '0;
    else if (merge) merge_cnt <= merge_cnt + 32'd1;
  end
`else
  assign merge     = 1'b0;
  assign merge_cnt = '0;
`endif

  // A same-edge dequeue frees a slot, so a full queue can still accept.
  assign push = req_valid && !flush && !merge && (!full || pop);
  assign drop = req_valid && !flush && !merge && full && !pop;

  l2q_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .push_data (req_addr),
    .head_data (mem_addr),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enq_cnt  <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      enq_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push) enq_cnt  <= enq_cnt + 32'd1;
      if (drop) drop_cnt <= drop_cnt + 32'd1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && n == CMD_PRINT) begin
      $display("l2q: count=%0h enq=%0h drop=%0h merge=%0h", count, enq_cnt, drop_cnt, merge_cnt);
      for (int i = 0; i < int'(count); i++) begin
        logic [PW-1:0] idx;
        idx = u_fifo.head_ptr + PW'(i);
        $display("l2q:   [%0d] %h", i, u_fifo.mem[idx]);
      end
    end
  end
`endif

endmodule
